// File: rtl/bit_serial_alu_pkg.sv
// rtl/bit_serial_alu_pkg.sv - shared opcodes, FSM states and sizing helper
// Purpose: common definitions for the bit-serial add/subtract unit.
// Ports: none (package).
package bit_serial_alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width; N=2 still needs one bit to tell bit 0 from bit 1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_serial_alu_if.sv
// rtl/bit_serial_alu_if.sv - request/response bundle of the bit-serial ALU
// Purpose: groups the operation request and result/flag signals.
// Ports: start/op/a/b (request, master->slave); busy/done/result/carry_out/
//        overflow/zero (response, slave->master).
interface bit_serial_alu_if #(
  parameter int N = 8
);
  logic         start;
  logic         op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/bit_adder.sv
// rtl/bit_adder.sv - single-bit full adder cell
// Purpose: one full-adder slice reused every cycle by the serial ALU.
// Ports: in1, in2, carryin (inputs); sum, carryout (outputs).
module bit_adder (
  output logic sum,
  output logic carryout,
  input  logic in1,
  input  logic in2,
  input  logic carryin
);
  assign sum      = in1 ^ in2 ^ carryin;
  assign carryout = (in1 & in2) | (in1 & carryin) | (in2 & carryin);
endmodule

// File: rtl/bit_serial_alu.sv
// rtl/bit_serial_alu.sv - N-bit add/subtract processed one bit per clock
// Purpose: shifts operands LSB first through a single bit_adder, collecting
//          the result and carry/overflow/zero flags.
// Ports: clk (rising edge), rst_n (async, active low),
//        bus (bit_serial_alu_if.slave): start/op/a/b in, busy/done/result/
//        carry_out/overflow/zero out.
module bit_serial_alu
  import bit_serial_alu_pkg::*;
#(
  parameter int N = 8
) (
  input logic              clk,
  input logic              rst_n,
  bit_serial_alu_if.slave  bus
);
  localparam int             CW   = cnt_width(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic          carry;
  logic [CW-1:0] count;
  logic [N-1:0]  result_r;
  logic          carry_out_r;
  logic          overflow_r;
  logic          busy_r;
  logic          done_r;
  logic          sum;
  logic          carryout;

  bit_adder u_bit_adder (
    .sum      (sum),
    .carryout (carryout),
    .in1      (a_sr[0]),
    .in2      (b_sr[0]),
    .carryin  (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      carry       <= 1'b0;
      count       <= '0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            b_sr   <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
            carry  <= (bus.op != OP_ADD);
            count  <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          result_r <= {sum, result_r[N-1:1]};
          a_sr     <= {1'b0, a_sr[N-1:1]};
          b_sr     <= {1'b0, b_sr[N-1:1]};
          carry    <= carryout;
          count    <= count + 1'b1;
          if (count == LAST) begin
            // carry still holds the carry into the MSB at this edge.
            overflow_r  <= carry ^ carryout;
            carry_out_r <= carryout;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;
  // Partial results during RUN are not meaningful, so zero is held low there.
  assign bus.zero      = ~busy_r & ~(|result_r);

endmodule

// File: tb/tb_bit_serial_alu.sv
// tb/tb_bit_serial_alu.sv - scoreboard bench for bit_serial_alu (N=8 and N=4)
module tb_bit_serial_alu;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  bit_serial_alu_if #(.N(8)) bus8 ();
  bit_serial_alu_if #(.N(4)) bus4 ();

  bit_serial_alu #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  bit_serial_alu #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit w4, input logic s, input logic o,
                       input logic [7:0] a, input logic [7:0] b);
    if (w4) begin
      bus4.start = s; bus4.op = o; bus4.a = a[3:0]; bus4.b = b[3:0];
    end else begin
      bus8.start = s; bus8.op = o; bus8.a = a; bus8.b = b;
    end
  endtask

  // Counts negedges after the start edge until done; also tallies busy samples.
  task automatic wait_done(input bit w4, output int lat, output int bc, output bit got);
    int lim;
    lim = w4 ? 20 : 40;
    lat = 0; bc = 0; got = 1'b0;
    while (!got && lat < lim) begin
      @(negedge clk);
      if (w4 ? bus4.done : bus8.done) got = 1'b1;
      else begin
        if (w4 ? bus4.busy : bus8.busy) bc++;
        lat++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout: got none expected done within %0d cycles", lim);
    end
  endtask

  task automatic run_op(input bit w4, input logic o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ec, input logic ev, input logic ez);
    int lat, bc, n;
    bit got;
    exp_t e;
    n = w4 ? 4 : 8;
    e.r = {24'd0, er}; e.c = ec; e.v = ev; e.z = ez;
    if (w4) q4.push_back(e); else q8.push_back(e);
    @(posedge clk); #1 drive(w4, 1'b1, o, a, b);
    @(posedge clk); #1 drive(w4, 1'b0, o, a, b);
    wait_done(w4, lat, bc, got);
    if (got && !w4) begin
      chk("latency", lat, n);
      chk("busy_cycles", bc, n);
    end
  endtask

  // Scoreboard monitors: every done must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus8.done) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done8: got done expected none (result %0h)", bus8.result);
      end else begin
        e = q8.pop_front();
        chk("result8", {24'd0, bus8.result}, e.r);
        chk("carry8", bus8.carry_out, e.c);
        chk("ovf8", bus8.overflow, e.v);
        chk("zero8", bus8.zero, e.z);
        chk("busy_with_done8", bus8.busy, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus4.done) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done4: got done expected none (result %0h)", bus4.result);
      end else begin
        e = q4.pop_front();
        chk("result4", {28'd0, bus4.result}, e.r);
        chk("carry4", bus4.carry_out, e.c);
        chk("ovf4", bus4.overflow, e.v);
        chk("zero4", bus4.zero, e.z);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc;
    bit got;
    logic [4:0] s;
    logic [3:0] r, bb;
    logic v;
    exp_t e;

    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus8.busy, 1'b0);
    chk("rst_done", bus8.done, 1'b0);
    chk("rst_result", bus8.result, 8'h00);
    chk("rst_carry", bus8.carry_out, 1'b0);
    chk("rst_ovf", bus8.overflow, 1'b0);
    chk("rst_zero", bus8.zero, 1'b1);
    rst_n = 1'b1;

    // Directed vectors, issued back to back.
    run_op(1'b0, 1'b0, 8'd100, 8'd27, 8'd127, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op(1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op(1'b0, 1'b1, 8'd5, 8'd7, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);

    // start during RUN and during DONE must be ignored.
    e.r = 32'd50; e.c = 1'b0; e.v = 1'b0; e.z = 1'b0;
    q8.push_back(e);
    @(posedge clk); #1 drive(1'b0, 1'b1, 1'b0, 8'd20, 8'd30);
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 8'd20, 8'd30);
    repeat (3) @(posedge clk);
    #1 drive(1'b0, 1'b1, 1'b1, 8'hAA, 8'h11);
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b1, 8'hAA, 8'h11);
    wait_done(1'b0, lat, bc, got);
    drive(1'b0, 1'b1, 1'b1, 8'h0F, 8'h0F);
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (10) @(negedge clk);
    chk("held_result", bus8.result, 8'd50);
    chk("held_zero", bus8.zero, 1'b0);
    chk("idle_busy", bus8.busy, 1'b0);
    run_op(1'b0, 1'b1, 8'd200, 8'd100, 8'd100, 1'b1, 1'b1, 1'b0);
    run_op(1'b0, 1'b0, 8'd10, 8'd20, 8'd30, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN aborts the operation with no done.
    @(posedge clk); #1 drive(1'b0, 1'b1, 1'b0, 8'd3, 8'd4);
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 8'd3, 8'd4);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus8.busy, 1'b0);
    chk("abort_done", bus8.done, 1'b0);
    chk("abort_result", bus8.result, 8'h00);
    chk("abort_carry", bus8.carry_out, 1'b0);
    chk("abort_ovf", bus8.overflow, 1'b0);
    chk("abort_zero", bus8.zero, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op(1'b0, 1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0);

    // Exhaustive N=4 sweep against an independent reference model.
    for (int o = 0; o < 2; o++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          bb = (o == 1) ? ~ib[3:0] : ib[3:0];
          s = {1'b0, ia[3:0]} + {1'b0, bb} + {4'd0, o[0]};
          r = s[3:0];
          if (o == 0) v = (ia[3] == ib[3]) && (r[3] != ia[3]);
          else        v = (ia[3] != ib[3]) && (r[3] != ia[3]);
          run_op(1'b1, o[0], {4'd0, ia[3:0]}, {4'd0, ib[3:0]},
                 {4'd0, r}, s[4], v, (r == 4'd0));
        end
      end
    end

    repeat (4) @(negedge clk);
    chk("pending8", q8.size(), 0);
    chk("pending4", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
